// File: rtl/mips_cpu_instr_memory_if.sv
// Program-load and instruction-fetch bus between the CPU/loader side and the instruction memory.
interface mips_cpu_instr_memory_if;
  // A byte moves on a rising clk edge when load_valid and load_ready are both high
  // (and the memory is clock-enabled). The sender holds load_data/load_last stable while
  // load_valid is high and not yet accepted. load_ready never depends on load_valid.
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        loaded;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        fetch_error;

  modport master (
    output load_valid, load_data, load_last, instr_address,
    input  load_ready, loaded, instr_readdata, fetch_error
  );

  modport slave (
    input  load_valid, load_data, load_last, instr_address,
    output load_ready, loaded, instr_readdata, fetch_error
  );
endinterface

// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory: clears itself, takes a byte-streamed big-endian program image,
// then serves zero-latency word fetches with a sticky illegal-fetch flag.
module mips_cpu_instr_memory #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  mips_cpu_instr_memory_if.slave   bus,
  output logic [1:0]               dbg_state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LW = AW + 2;
  localparam logic [31:0]   WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [AW-1:0] LAST_WORD = '1;
  localparam logic [LW-1:0] LAST_BYTE = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [LW-1:0] ld_ptr_q, ld_ptr_d;
  logic          fetch_error_q, fetch_error_d;
  logic          clear_we, load_we;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_win, aligned, halt_addr, fetch_bad;
  logic [31:0]   rd_word;
  logic [4:0]    lane_sh;

  // Read path: word index comes from the byte offset relative to the reset vector.
  assign offset    = bus.instr_address - BASE_ADDR;
  assign in_win    = offset < WIN_BYTES;
  assign aligned   = bus.instr_address[1:0] == 2'b00;
  assign halt_addr = bus.instr_address == 32'h0;
  assign fetch_bad = !halt_addr && (!in_win || !aligned);
  assign rd_word   = mem_q[offset[AW+1:2]];

  // Storage is big-endian; the CPU sees the word byte-reversed.
  assign bus.instr_readdata = (state_q == ST_RUN && in_win && aligned && !halt_addr)
                            ? {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]}
                            : 32'h0;

  assign bus.load_ready  = state_q == ST_LOAD;
  assign bus.loaded      = state_q == ST_RUN;
  assign bus.fetch_error = fetch_error_q;
  assign dbg_state_o     = state_q;

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    ld_ptr_d      = ld_ptr_q;
    fetch_error_d = fetch_error_q;
    clear_we      = 1'b0;
    load_we       = 1'b0;
    if (clk_enable) begin
      case (state_q)
        ST_CLEAR: begin
          clear_we  = 1'b1;
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_WORD) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (bus.load_valid) begin
            load_we  = 1'b1;
            ld_ptr_d = ld_ptr_q + 1'b1;
            // A full image ends the load even without load_last; nothing wraps.
            if (bus.load_last || ld_ptr_q == LAST_BYTE) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (fetch_bad) fetch_error_d = 1'b1;
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      ld_ptr_q      <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      ld_ptr_q      <= ld_ptr_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  // Byte lane 0 of each word is its MSB.
  assign lane_sh = {~ld_ptr_q[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_we)
        mem_q[clr_ptr_q] <= 32'h0;
      else if (load_we)
        mem_q[ld_ptr_q[LW-1:2]][lane_sh +: 8] <= bus.load_data;
    end
  end

endmodule

// File: doc/mips_cpu_instr_memory.md
MIPS_CPU_INSTR_MEMORY -- requirements
Module: mips_cpu_instr_memory

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the instruction storage size in 32-bit words (power of two, 4..1024).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'hBFC00000, giving the byte address of word 0 (the CPU reset vector).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port clk_enable  input  1  when low, all non-reset state holds.
REQ-006 The block SHALL have port load_valid  input  1  a program byte is offered on load_data.
REQ-007 The block SHALL have port load_data  input  8  program byte, in increasing byte-address order from BASE_ADDR.
REQ-008 The block SHALL have port load_last  input  1  qualifies the final byte of the program image.
REQ-009 The block SHALL have port load_ready  output  1  the block accepts a byte this cycle.
REQ-010 The block SHALL have port loaded  output  1  the image is complete and fetches are served.
REQ-011 The block SHALL have port instr_address  input  32  CPU fetch byte address.
REQ-012 The block SHALL have port instr_readdata  output  32  fetched word, presented in CPU-side byte order.
REQ-013 The block SHALL have port fetch_error  output  1  sticky flag for an illegal fetch.

Function
REQ-014 The block SHALL implement states CLEAR, LOAD and RUN; reset SHALL force CLEAR with clear pointer 0, load pointer 0 and fetch_error 0.
REQ-015 In CLEAR, each enabled cycle SHALL zero word[clear pointer] and increment the pointer; after word DEPTH_WORDS-1 is zeroed the state SHALL become LOAD.
REQ-016 load_ready SHALL be 1 only in LOAD.
REQ-017 loaded SHALL be 1 only in RUN.
REQ-018 A byte SHALL be accepted when load_valid, load_ready and clk_enable are all 1 at an edge; load_valid SHALL be ignored in any other state.
REQ-019 An accepted byte SHALL be written to byte[load pointer], and the pointer SHALL increment by 1.
REQ-020 Byte offset 4k+0 SHALL be the MSB of word k (big-endian storage).
REQ-021 Acceptance with load_last=1 SHALL move LOAD to RUN.
REQ-022 Acceptance of byte DEPTH_WORDS*4-1 SHALL move LOAD to RUN regardless of load_last; there SHALL be no wrap-around.
REQ-023 instr_readdata SHALL be combinational from instr_address with zero latency.
REQ-024 For stored bytes b0..b3 at word index (instr_address-BASE_ADDR)>>2, instr_readdata SHALL be {b3,b2,b1,b0}.
REQ-025 instr_readdata SHALL be 32'h0 when the state is not RUN.
REQ-026 instr_readdata SHALL be 32'h0 when instr_address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
REQ-027 instr_readdata SHALL be 32'h0 when instr_address[1:0]!=0.
REQ-028 In RUN with clk_enable=1, fetch_error SHALL be set at the edge when instr_address is out of window or misaligned.
REQ-029 instr_address==32'h0 (CPU halt address) SHALL return 0 and SHALL NOT set fetch_error.
REQ-030 fetch_error SHALL clear only on reset.
REQ-031 clk_enable=0 SHALL freeze state, pointers, memory and fetch_error; reads SHALL stay live.
REQ-032 Reset asserted in any state (including mid-LOAD) SHALL restart CLEAR at the next edge; partially loaded contents SHALL be discarded by the clear.

Reset
REQ-033 After reset the outputs SHALL be load_ready=0, loaded=0, fetch_error=0 and instr_readdata=0.
REQ-034 With clk_enable=1, load_ready SHALL rise exactly DEPTH_WORDS edges after the first edge sampling reset=0.

Verification
REQ-035 Reset, then idle: load_ready=0 for 64 cycles and 1 on cycle 64; loaded=0 throughout.
REQ-036 Load 84 02 00 00 00 00 00 08 24 00 00 00 with load_last on the final byte: loaded=1 next cycle; BFC00000->32'h00000284, BFC00004->32'h08000000, BFC00008->32'h00000024, BFC0000C->0.
REQ-037 In RUN, fetch BFC00002 -> readdata 0, fetch_error=1 next edge and held; fetch 0x0 after reset plus reload -> fetch_error stays 0.
REQ-038 Stream 256 bytes with no load_last (DEPTH_WORDS=64): RUN after byte 255; a 257th load_valid is ignored; BFC000FC returns the last four bytes swapped.
REQ-039 Hold clk_enable=0 for 10 cycles mid-LOAD with load_valid=1: pointer unchanged, no bytes written, load_ready still 1.
REQ-040 Assert reset after 5 loaded bytes, then reload 4 bytes 11 22 33 44 with load_last: BFC00000->32'h44332211 and BFC00004->0.
